// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I-subset decode stage sitting directly after fetch. It decodes the
//   control word for InstrD, sign-extends the immediate, reads the register
//   file (x1..x31, written back from the W stage) and registers everything
//   into the D->E pipeline register. FlushE loads a bubble. Reset is
//   synchronous and active-low.
//
// Ports
//   clk, reset                       clock, synchronous active-low reset
//   InstrD, PCD, PCPlus4D            instruction and PCs from fetch register
//   FlushE                           load a bubble into the E register
//   RegWriteW, RdW, ResultW          register-file writeback port
//   Rs1D, Rs2D                       raw source fields (for hazard unit)
//   RegWriteE .. IllegalE            registered control
//   ResultSrcE (00 ALU,01 mem,10 PC+4), ALUControlE (000 add,001 sub,
//   010 and,011 or,101 slt)
//   RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE   registered data
//
// Configuration macro
//   REGFILE_BYPASS_EN : same-cycle writeback is forwarded to the read ports.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd     = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // ---------------- register file (x0 not stored) ----------------
  logic [XLEN-1:0] rf [1:NREG-1];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (!reset) begin
        rf[i] <= '0;
      end else if (RegWriteW && (RdW == 5'(i))) begin
        rf[i] <= ResultW;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != 5'd0) rd1 = rf[Rs1D];
    if (Rs2D != 5'd0) rd2 = rf[Rs2D];
`ifdef REGFILE_BYPASS_EN
    // Write-through: a write landing this edge is visible to this read.
    if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1D)) rd1 = ResultW;
    if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2D)) rd2 = ResultW;
`endif
  end

  // ---------------- control decode ----------------
  logic       reg_write;
  logic       mem_write;
  logic       jump;
  logic       branch;
  logic       alu_src;
  logic       illegal;
  logic [1:0] result_src;
  logic [2:0] alu_control;
  logic [XLEN-1:0] imm_ext;
  logic [2:0] alu_op_f3;
  logic       is_r;

  assign is_r = (opcode == OP_R);

  // ALU op from funct3; sub only for R-type with funct7[5] set (addi with
  // imm bit 10 set must still add).
  always_comb begin
    case (funct3)
      3'b000:  alu_op_f3 = (is_r && InstrD[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_op_f3 = 3'b101;
      3'b110:  alu_op_f3 = 3'b011;
      3'b111:  alu_op_f3 = 3'b010;
      default: alu_op_f3 = 3'b000;
    endcase
  end

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'b00;
    alu_control = 3'b000;
    imm_ext     = '0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_ext   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        reg_write   = 1'b1;
        alu_control = alu_op_f3;
      end
      OP_IALU: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = alu_op_f3;
        imm_ext     = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BEQ: begin
        branch      = 1'b1;
        alu_control = 3'b001;
        imm_ext     = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                       InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_ext    = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                      InstrD[20], InstrD[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  // ---------------- D->E pipeline register ----------------
  always_ff @(posedge clk) begin
    if (!reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      IllegalE    <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      IllegalE    <= illegal;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed control word: {RegWrite,MemWrite,Jump,Branch,ALUSrc,Illegal,ResultSrc,ALUControl}
  function automatic logic [31:0] ctrl();
    return {21'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE,
            ResultSrcE, ALUControlE};
  endfunction

  function automatic logic [31:0] mk(input logic rw, mw, j, b, as, il,
                                     input logic [1:0] rs, input logic [2:0] ac);
    return {21'd0, rw, mw, j, b, as, il, rs, ac};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input string what);
    $display("[%0t] %s ctrl=%h RD1E=%h RD2E=%h ImmExtE=%h RdE=%0d",
             $time, what, ctrl(), RD1E, RD2E, ImmExtE, RdE);
  endtask

  initial begin
    InstrD = 32'h0000_0013; PCD = 32'h0; PCPlus4D = 32'h4;
    FlushE = 1'b0; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hCAFE_F00D;
    reset = 1'b0;
    // 1: reset two cycles while writeback is attempted
    step(); step();
    line("reset");
    check("reset_ctrl", ctrl(), 32'h0);
    check("reset_pce", PCE, 32'h0);
    check("reset_pcplus4e", PCPlus4E, 32'h0);
    check("reset_rd1e", RD1E, 32'h0);
    reset = 1'b1; RegWriteW = 1'b0;
    InstrD = 32'h0002_8093;                 // addi x1,x5,0
    #1 check("rs1d_comb", {27'd0, Rs1D}, 32'd5);
    step(); line("read x5");
    check("x5_after_reset", RD1E, 32'h0);

    // 2: write x3=0xAA, then add x4,x3,x3
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0000_00AA; InstrD = 32'h0000_0013;
    step();
    RegWriteW = 1'b0; InstrD = 32'h0031_8233; PCD = 32'h100; PCPlus4D = 32'h104;
    step(); line("add x4,x3,x3");
    check("add_rd1e", RD1E, 32'hAA);
    check("add_rd2e", RD2E, 32'hAA);
    check("add_ctrl", ctrl(), mk(1,0,0,0,0,0,2'b00,3'b000));
    check("add_rde", {27'd0, RdE}, 32'd4);
    check("add_rs1e", {27'd0, Rs1E}, 32'd3);
    check("add_pce", PCE, 32'h100);
    check("add_pcplus4e", PCPlus4E, 32'h104);

    InstrD = 32'h4031_8233; step(); line("sub");            // sub x4,x3,x3
    check("sub_ctrl", ctrl(), mk(1,0,0,0,0,0,2'b00,3'b001));
    InstrD = 32'h0041_A133; step(); line("slt");            // slt x2,x3,x4
    check("slt_ctrl", ctrl(), mk(1,0,0,0,0,0,2'b00,3'b101));
    InstrD = 32'h0041_E133; step(); line("or");             // or x2,x3,x4
    check("or_ctrl", ctrl(), mk(1,0,0,0,0,0,2'b00,3'b011));
    InstrD = 32'h7FF1_F093; step(); line("andi");           // andi x1,x3,0x7ff
    check("andi_ctrl", ctrl(), mk(1,0,0,0,1,0,2'b00,3'b010));
    check("andi_imm", ImmExtE, 32'h0000_07FF);
    InstrD = 32'hC000_0093; step(); line("addi -1024");     // imm bit10 set: still add
    check("addi_neg_ctrl", ctrl(), mk(1,0,0,0,1,0,2'b00,3'b000));
    check("addi_neg_imm", ImmExtE, 32'hFFFF_FC00);

    // 3: lw, beq, sw, jal immediates
    InstrD = 32'hFFC1_2083; step(); line("lw x1,-4(x2)");
    check("lw_ctrl", ctrl(), mk(1,0,0,0,1,0,2'b01,3'b000));
    check("lw_imm", ImmExtE, 32'hFFFF_FFFC);
    InstrD = 32'hFE00_0EE3; step(); line("beq x0,x0,-4");
    check("beq_ctrl", ctrl(), mk(0,0,0,1,0,0,2'b00,3'b001));
    check("beq_imm", ImmExtE, 32'hFFFF_FFFC);
    InstrD = 32'hFE51_2C23; step(); line("sw x5,-8(x2)");
    check("sw_ctrl", ctrl(), mk(0,1,0,0,1,0,2'b00,3'b000));
    check("sw_imm", ImmExtE, 32'hFFFF_FFF8);
    InstrD = 32'hFFFF_F0EF; step(); line("jal x1,-2");
    check("jal_ctrl", ctrl(), mk(1,0,1,0,0,0,2'b10,3'b000));
    check("jal_imm_neg", ImmExtE, 32'hFFFF_FFFE);
    InstrD = 32'h0010_006F; step(); line("jal x0,0x800");
    check("jal_imm_pos", ImmExtE, 32'h0000_0800);

    // 4: write to x0 ignored
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hDEAD_BEEF; InstrD = 32'h0000_0013;
    step();
    RegWriteW = 1'b0; InstrD = 32'h0050_0093;               // addi x1,x0,5
    step(); line("read x0");
    check("x0_read", RD1E, 32'h0);

    // 5: same-cycle write and read of x7
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h0000_0055; InstrD = 32'h0000_0013;
    step();
    ResultW = 32'h0000_1234; InstrD = 32'h0003_8433;        // add x8,x7,x0
    step(); line("same-cycle x7");
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", RD1E, 32'h0000_1234);
`else
    check("x7_same_cycle", RD1E, 32'h0000_0055);
`endif
    RegWriteW = 1'b0;
    step(); line("x7 next cycle");
    check("x7_next_cycle", RD1E, 32'h0000_1234);

    // 6: illegal opcode, then flush
    InstrD = 32'hFFFF_FFFF; step(); line("illegal");
    check("illegal_ctrl", ctrl(), mk(0,0,0,0,0,1,2'b00,3'b000));
    FlushE = 1'b1; step(); line("flush");
    check("flush_ctrl", ctrl(), 32'h0);
    check("flush_imm", ImmExtE, 32'h0);
    check("flush_rs1e", {27'd0, Rs1E}, 32'h0);
    FlushE = 1'b0;

    // reset mid-operation discards in-flight writeback and clears x7
    reset = 1'b0; RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h1111_2222;
    step();
    reset = 1'b1; RegWriteW = 1'b0; InstrD = 32'h0093_8433; // add x8,x7,x9
    step(); line("after mid reset");
    check("mid_reset_x7", RD1E, 32'h0);
    check("mid_reset_x9", RD2E, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
